// File: rtl/pipe_stage_elastic_pkg.sv
// Shared pipeline definitions for the elastic inter-stage registers.
//
// Contents:
//   OCC_W        width of the occupancy count (0..2 entries)
//   CTRL_MAX_W   widest control bundle any stage may carry
//   BUBBLE_CTRL  all-zero control word driven whenever a stage holds no entry
//   *_DATA_W / *_CTRL_W   per-boundary widths so IF/ID .. MEM/WB instances agree
//   occ_e        symbolic occupancy values
//   occ_count()  occupancy from the two valid bits
package pipe_stage_elastic_pkg;

    localparam int OCC_W      = 2;
    localparam int CTRL_MAX_W = 64;

    // Sliced down to CTRL_W by each stage; CTRL_W must not exceed CTRL_MAX_W.
    localparam logic [CTRL_MAX_W-1:0] BUBBLE_CTRL = '0;

    // IF/ID: PC+4 and fetched instruction.
    localparam int IFID_DATA_W  = 64;
    localparam int IFID_CTRL_W  = 1;
    // ID/EX: PC+4, two register operands, sign-extended immediate.
    localparam int IDEX_DATA_W  = 128;
    localparam int IDEX_CTRL_W  = 8;
    // EX/MEM: ALU result, store data, destination register.
    localparam int EXMEM_DATA_W = 72;
    localparam int EXMEM_CTRL_W = 5;
    // MEM/WB: load data, ALU result, destination register.
    localparam int MEMWB_DATA_W = 72;
    localparam int MEMWB_CTRL_W = 3;

    typedef enum logic [OCC_W-1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_TWO   = 2'd2
    } occ_e;

    function automatic logic [OCC_W-1:0] occ_count(input logic main_v, input logic skid_v);
        return {1'b0, main_v} + {1'b0, skid_v};
    endfunction

endpackage

// File: rtl/pipe_stage_elastic_if.sv
// Valid/ready handshake bundle between two pipeline stages.
//
// Signals:
//   valid  producer has an entry this cycle
//   ready  consumer can take it this cycle
//   data   opaque data bundle (DATA_W)
//   ctrl   control bundle (CTRL_W)
//
// Modports:
//   master  producer side (drives valid/data/ctrl, samples ready)
//   slave   consumer side (samples valid/data/ctrl, drives ready)
interface pipe_stage_elastic_if #(
    parameter int DATA_W = 64,
    parameter int CTRL_W = 8
);

    logic              valid;
    logic              ready;
    logic [DATA_W-1:0] data;
    logic [CTRL_W-1:0] ctrl;

    modport master (
        output valid,
        output data,
        output ctrl,
        input  ready
    );

    modport slave (
        input  valid,
        input  data,
        input  ctrl,
        output ready
    );

endinterface

// File: rtl/pipe_stage_elastic_entry_reg.sv
// One pipeline entry: valid bit plus data and control registers.
//
// Ports:
//   clk, rst   clock and synchronous active-high reset (clears everything)
//   clr        drop the entry: valid and ctrl go to 0, data keeps its value
//   ld         capture ld_data/ld_ctrl and mark the entry valid
//   ld_data    data to capture
//   ld_ctrl    control to capture
//   v, d, c    registered valid, data, control
//
// Priority is rst > clr > ld > hold.
module pipe_entry_reg #(
    parameter int DATA_W = 64,
    parameter int CTRL_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              ld,
    input  logic [DATA_W-1:0] ld_data,
    input  logic [CTRL_W-1:0] ld_ctrl,
    output logic              v,
    output logic [DATA_W-1:0] d,
    output logic [CTRL_W-1:0] c
);

    always_ff @(posedge clk) begin
        if (rst) begin
            v <= 1'b0;
            d <= '0;
            c <= '0;
        end else if (clr) begin
            // Control is zeroed so an empty entry never carries live
            // RegWrite/MemWrite/Halt bits, even internally.
            v <= 1'b0;
            c <= '0;
        end else if (ld) begin
            v <= 1'b1;
            d <= ld_data;
            c <= ld_ctrl;
        end
    end

endmodule

// File: rtl/pipe_stage_elastic.sv
// Handshaked pipeline stage register with optional one-entry skid buffer.
//
// Ports:
//   clk, rst    clock and synchronous active-high reset
//   up          upstream handshake (slave): valid/data/ctrl in, ready out
//   dn          downstream handshake (master): valid/data/ctrl out, ready in
//   freeze      hold every register; no accept, no release
//   flush       drop every held entry (data held, ctrl zeroed)
//   occupancy   number of valid entries, 0..2 (never above 1 without skid)
//
// With SKID_EN=1 upstream ready depends only on the skid register (and
// freeze), so there is no combinational path from dn.ready to up.ready.
// With SKID_EN=0 a single register is used and up.ready = !main_v | dn.ready.
//
// Occupancy states (main_v, skid_v):
//   state     | meaning
//   OCC_EMPTY | no entry; dn.valid=0, dn.ctrl forced to zero
//   OCC_ONE   | head in main, skid empty; can accept and release together
//   OCC_TWO   | head in main, next entry in skid; up.ready=0 until skid drains
module pipe_stage_elastic
    import pipe_stage_elastic_pkg::*;
#(
    parameter int DATA_W  = 64,
    parameter int CTRL_W  = 8,
    parameter bit SKID_EN = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    pipe_stage_elastic_if.slave   up,
    pipe_stage_elastic_if.master  dn,
    input  logic                  freeze,
    input  logic                  flush,
    output logic [OCC_W-1:0]      occupancy
);

    logic              main_v;
    logic [DATA_W-1:0] main_d;
    logic [CTRL_W-1:0] main_c;
    logic              skid_v;
    logic [DATA_W-1:0] skid_d;
    logic [CTRL_W-1:0] skid_c;

    logic              in_ready;
    logic              acc;
    logic              rel;

    logic              main_ld;
    logic              main_clr;
    logic              main_from_skid;
    logic              skid_ld;
    logic              skid_clr;
    logic [DATA_W-1:0] main_ld_data;
    logic [CTRL_W-1:0] main_ld_ctrl;

    generate
        if (SKID_EN) begin : g_ready_skid
            assign in_ready = ~skid_v & ~freeze;
        end else begin : g_ready_flat
            assign in_ready = (~main_v | dn.ready) & ~freeze;
        end
    endgenerate

    assign acc = up.valid & in_ready & ~freeze;
    assign rel = main_v & dn.ready & ~freeze;

    // Flush beats freeze; reset is handled inside the entry registers and
    // beats both. With SKID_EN=0, skid_v is constantly 0, so the skid
    // branches below are never taken and one decode serves both variants.
    always_comb begin
        main_ld        = 1'b0;
        main_clr       = 1'b0;
        main_from_skid = 1'b0;
        skid_ld        = 1'b0;
        skid_clr       = 1'b0;
        if (flush) begin
            main_clr = 1'b1;
            skid_clr = 1'b1;
        end else if (!freeze) begin
            if (!main_v) begin
                main_ld = acc;
            end else if (rel) begin
                if (skid_v) begin
                    // Skid moves up; in_ready was 0 so nothing new arrives.
                    main_ld        = 1'b1;
                    main_from_skid = 1'b1;
                    skid_clr       = 1'b1;
                end else if (acc) begin
                    main_ld = 1'b1;
                end else begin
                    main_clr = 1'b1;
                end
            end else if (acc) begin
                // Head is stalled but we already promised ready: park in skid.
                skid_ld = 1'b1;
            end
        end
    end

    assign main_ld_data = main_from_skid ? skid_d : up.data;
    assign main_ld_ctrl = main_from_skid ? skid_c : up.ctrl;

    pipe_entry_reg #(
        .DATA_W (DATA_W),
        .CTRL_W (CTRL_W)
    ) u_main (
        .clk     (clk),
        .rst     (rst),
        .clr     (main_clr),
        .ld      (main_ld),
        .ld_data (main_ld_data),
        .ld_ctrl (main_ld_ctrl),
        .v       (main_v),
        .d       (main_d),
        .c       (main_c)
    );

    generate
        if (SKID_EN) begin : g_skid
            pipe_entry_reg #(
                .DATA_W (DATA_W),
                .CTRL_W (CTRL_W)
            ) u_skid (
                .clk     (clk),
                .rst     (rst),
                .clr     (skid_clr),
                .ld      (skid_ld),
                .ld_data (up.data),
                .ld_ctrl (up.ctrl),
                .v       (skid_v),
                .d       (skid_d),
                .c       (skid_c)
            );
        end else begin : g_no_skid
            logic unused_skid;
            assign skid_v      = 1'b0;
            assign skid_d      = '0;
            assign skid_c      = '0;
            assign unused_skid = skid_ld | skid_clr;
        end
    endgenerate

    assign up.ready  = in_ready;
    assign dn.valid  = main_v;
    assign dn.data   = main_d;
    assign dn.ctrl   = main_v ? main_c : BUBBLE_CTRL[CTRL_W-1:0];
    assign occupancy = occ_count(main_v, skid_v);

endmodule

// File: tb/tb_pipe_stage_elastic.sv
module tb_pipe_stage_elastic;

    logic       clk = 1'b0;
    logic       rst_s, flush_s, freeze_s;
    logic       rst_n, flush_n, freeze_n;
    logic [1:0] occ_s, occ_n;

    int n_checks = 0;
    int n_fail   = 0;
    bit mon_en   = 1'b0;

    always #5 clk = ~clk;

    pipe_stage_elastic_if #(.DATA_W(16), .CTRL_W(8)) up_s ();
    pipe_stage_elastic_if #(.DATA_W(16), .CTRL_W(8)) dn_s ();
    pipe_stage_elastic_if #(.DATA_W(16), .CTRL_W(8)) up_n ();
    pipe_stage_elastic_if #(.DATA_W(16), .CTRL_W(8)) dn_n ();

    pipe_stage_elastic #(.DATA_W(16), .CTRL_W(8), .SKID_EN(1'b1)) dut_s (
        .clk       (clk),
        .rst       (rst_s),
        .up        (up_s),
        .dn        (dn_s),
        .freeze    (freeze_s),
        .flush     (flush_s),
        .occupancy (occ_s)
    );

    pipe_stage_elastic #(.DATA_W(16), .CTRL_W(8), .SKID_EN(1'b0)) dut_n (
        .clk       (clk),
        .rst       (rst_n),
        .up        (up_n),
        .dn        (dn_n),
        .freeze    (freeze_n),
        .flush     (flush_n),
        .occupancy (occ_n)
    );

    typedef struct {
        logic        rst;
        logic        flush;
        logic        freeze;
        logic        iv;
        logic [15:0] id;
        logic [7:0]  ic;
        logic        ordy;
        logic        e_ir;
        logic        e_ov;
        logic [15:0] e_od;
        logic [7:0]  e_oc;
        logic [1:0]  e_occ;
    } vec_t;

    vec_t vs_s[$];
    vec_t vs_n[$];

    function automatic vec_t mk(input logic r, input logic fl, input logic fz, input logic iv,
                                input logic [15:0] id, input logic [7:0] ic, input logic ordy,
                                input logic eir, input logic eov, input logic [15:0] eod,
                                input logic [7:0] eoc, input logic [1:0] eocc);
        vec_t v;
        v.rst = r; v.flush = fl; v.freeze = fz; v.iv = iv; v.id = id; v.ic = ic; v.ordy = ordy;
        v.e_ir = eir; v.e_ov = eov; v.e_od = eod; v.e_oc = eoc; v.e_occ = eocc;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Drive one cycle of inputs at the falling edge, then compare the
    // outputs seen before the next rising edge.
    task automatic apply(input bit sel_n, input string tag, input vec_t v);
        @(negedge clk);
        if (sel_n) begin
            rst_n = v.rst; flush_n = v.flush; freeze_n = v.freeze;
            up_n.valid = v.iv; up_n.data = v.id; up_n.ctrl = v.ic; dn_n.ready = v.ordy;
            #1;
            chk({tag, ".in_ready"},  {31'd0, up_n.ready}, {31'd0, v.e_ir});
            chk({tag, ".out_valid"}, {31'd0, dn_n.valid}, {31'd0, v.e_ov});
            chk({tag, ".out_data"},  {16'd0, dn_n.data},  {16'd0, v.e_od});
            chk({tag, ".out_ctrl"},  {24'd0, dn_n.ctrl},  {24'd0, v.e_oc});
            chk({tag, ".occupancy"}, {30'd0, occ_n},      {30'd0, v.e_occ});
        end else begin
            rst_s = v.rst; flush_s = v.flush; freeze_s = v.freeze;
            up_s.valid = v.iv; up_s.data = v.id; up_s.ctrl = v.ic; dn_s.ready = v.ordy;
            #1;
            chk({tag, ".in_ready"},  {31'd0, up_s.ready}, {31'd0, v.e_ir});
            chk({tag, ".out_valid"}, {31'd0, dn_s.valid}, {31'd0, v.e_ov});
            chk({tag, ".out_data"},  {16'd0, dn_s.data},  {16'd0, v.e_od});
            chk({tag, ".out_ctrl"},  {24'd0, dn_s.ctrl},  {24'd0, v.e_oc});
            chk({tag, ".occupancy"}, {30'd0, occ_s},      {30'd0, v.e_occ});
        end
    endtask

    // Skid may only hold an entry when the head does.
    always @(posedge clk) begin
        #1;
        if (mon_en) begin
            n_checks++;
            if (dut_s.skid_v === 1'b1 && dut_s.main_v !== 1'b1) begin
                n_fail++;
                $display("FAIL skid_implies_main: skid_v=%b main_v=%b", dut_s.skid_v, dut_s.main_v);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not reach its end");
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] q[$];
        logic [15:0] exp_d;
        logic [15:0] pat;
        int sent;
        int got;

        // Columns: rst flush freeze in_valid in_data in_ctrl out_ready |
        //          in_ready out_valid out_data out_ctrl occupancy
        // Stream with out_ready=1.
        vs_s.push_back(mk(0,0,0,1,16'h1,8'h81,1, 1,0,16'h0,8'h00,0));
        vs_s.push_back(mk(0,0,0,1,16'h2,8'h81,1, 1,1,16'h1,8'h81,1));
        vs_s.push_back(mk(0,0,0,1,16'h3,8'h81,1, 1,1,16'h2,8'h81,1));
        vs_s.push_back(mk(0,0,0,1,16'h4,8'h81,1, 1,1,16'h3,8'h81,1));
        vs_s.push_back(mk(0,0,0,1,16'h5,8'h81,1, 1,1,16'h4,8'h81,1));
        vs_s.push_back(mk(0,0,0,0,16'h0,8'h00,1, 1,1,16'h5,8'h81,1));
        vs_s.push_back(mk(0,0,0,0,16'h0,8'h00,0, 1,0,16'h5,8'h00,0));
        // Backpressure fill, then drain.
        vs_s.push_back(mk(0,0,0,1,16'hA,8'h81,0, 1,0,16'h5,8'h00,0));
        vs_s.push_back(mk(0,0,0,1,16'hB,8'h81,0, 1,1,16'hA,8'h81,1));
        vs_s.push_back(mk(0,0,0,1,16'hC,8'h81,0, 0,1,16'hA,8'h81,2));
        vs_s.push_back(mk(0,0,0,1,16'hC,8'h81,0, 0,1,16'hA,8'h81,2));
        vs_s.push_back(mk(0,0,0,1,16'hC,8'h81,1, 0,1,16'hA,8'h81,2));
        vs_s.push_back(mk(0,0,0,1,16'hC,8'h81,1, 1,1,16'hB,8'h81,1));
        vs_s.push_back(mk(0,0,0,0,16'h0,8'h00,1, 1,1,16'hC,8'h81,1));
        vs_s.push_back(mk(0,0,0,0,16'h0,8'h00,0, 1,0,16'hC,8'h00,0));
        // Flush with a full stage and a new entry offered.
        vs_s.push_back(mk(0,0,0,1,16'h21,8'hFF,0, 1,0,16'hC,8'h00,0));
        vs_s.push_back(mk(0,0,0,1,16'h22,8'hFF,0, 1,1,16'h21,8'hFF,1));
        vs_s.push_back(mk(0,1,0,1,16'hD,8'hFF,0,  0,1,16'h21,8'hFF,2));
        vs_s.push_back(mk(0,0,0,0,16'h0,8'h00,1,  1,0,16'h21,8'h00,0));
        vs_s.push_back(mk(0,0,0,0,16'h0,8'h00,1,  1,0,16'h21,8'h00,0));
        // Freeze for three cycles.
        vs_s.push_back(mk(0,0,0,1,16'h7,8'h81,0, 1,0,16'h21,8'h00,0));
        vs_s.push_back(mk(0,0,1,1,16'h8,8'h81,1, 0,1,16'h7,8'h81,1));
        vs_s.push_back(mk(0,0,1,1,16'h8,8'h81,1, 0,1,16'h7,8'h81,1));
        vs_s.push_back(mk(0,0,1,1,16'h8,8'h81,1, 0,1,16'h7,8'h81,1));
        vs_s.push_back(mk(0,0,0,1,16'h8,8'h81,1, 1,1,16'h7,8'h81,1));
        vs_s.push_back(mk(0,0,0,0,16'h0,8'h00,1, 1,1,16'h8,8'h81,1));
        vs_s.push_back(mk(0,0,0,0,16'h0,8'h00,0, 1,0,16'h8,8'h00,0));
        // Reset with a full stage, freeze also asserted.
        vs_s.push_back(mk(0,0,0,1,16'h31,8'hFF,0, 1,0,16'h8,8'h00,0));
        vs_s.push_back(mk(0,0,0,1,16'h32,8'hFF,0, 1,1,16'h31,8'hFF,1));
        vs_s.push_back(mk(1,0,1,1,16'h33,8'hFF,0, 0,1,16'h31,8'hFF,2));
        vs_s.push_back(mk(0,0,0,0,16'h0,8'h00,1,  1,0,16'h0,8'h00,0));

        // Single-register variant: in_ready follows out_ready while full.
        vs_n.push_back(mk(0,0,0,1,16'h10,8'h81,1, 1,0,16'h0,8'h00,0));
        vs_n.push_back(mk(0,0,0,1,16'h11,8'h81,0, 0,1,16'h10,8'h81,1));
        vs_n.push_back(mk(0,0,0,1,16'h11,8'h81,1, 1,1,16'h10,8'h81,1));
        vs_n.push_back(mk(0,0,0,1,16'h12,8'h81,0, 0,1,16'h11,8'h81,1));
        vs_n.push_back(mk(0,0,0,1,16'h12,8'h81,1, 1,1,16'h11,8'h81,1));
        vs_n.push_back(mk(0,0,0,1,16'h13,8'h81,0, 0,1,16'h12,8'h81,1));
        vs_n.push_back(mk(0,0,0,1,16'h13,8'h81,1, 1,1,16'h12,8'h81,1));
        vs_n.push_back(mk(0,0,0,0,16'h0,8'h00,0,  0,1,16'h13,8'h81,1));
        vs_n.push_back(mk(0,0,0,0,16'h0,8'h00,1,  1,1,16'h13,8'h81,1));
        vs_n.push_back(mk(0,0,0,0,16'h0,8'h00,0,  1,0,16'h13,8'h00,0));
        vs_n.push_back(mk(0,0,1,1,16'h14,8'h81,1, 0,0,16'h13,8'h00,0));
        vs_n.push_back(mk(0,0,0,0,16'h0,8'h00,0,  1,0,16'h13,8'h00,0));

        rst_s = 1'b1; flush_s = 1'b0; freeze_s = 1'b0;
        rst_n = 1'b1; flush_n = 1'b0; freeze_n = 1'b0;
        up_s.valid = 1'b0; up_s.data = '0; up_s.ctrl = '0; dn_s.ready = 1'b0;
        up_n.valid = 1'b0; up_n.data = '0; up_n.ctrl = '0; dn_n.ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_s = 1'b0;
        rst_n = 1'b0;
        mon_en = 1'b1;

        foreach (vs_s[i]) apply(1'b0, $sformatf("skid[%0d]", i), vs_s[i]);

        // Flush takes priority over freeze on a full stage.
        apply(1'b0, "prio0", mk(0,0,0,1,16'h41,8'h05,0, 1,0,16'h0,8'h00,0));
        apply(1'b0, "prio1", mk(0,0,0,1,16'h42,8'h05,0, 1,1,16'h41,8'h05,1));
        apply(1'b0, "prio2", mk(0,1,1,1,16'h43,8'h05,1, 0,1,16'h41,8'h05,2));
        apply(1'b0, "prio3", mk(0,0,0,0,16'h0,8'h00,0,  1,0,16'h41,8'h00,0));

        // Irregular backpressure: six entries must emerge once each, in order.
        pat  = 16'b0011_1001_0001_1101;
        sent = 0;
        got  = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk);
            up_s.valid = (sent < 6);
            up_s.data  = 16'h50 + 16'(sent);
            up_s.ctrl  = 8'h3C;
            dn_s.ready = pat[cyc % 16];
            #1;
            if (dn_s.valid && dn_s.ready) begin
                if (q.size() == 0) begin
                    chk("order.spurious", {16'd0, dn_s.data}, 32'hFFFF_FFFF);
                end else begin
                    exp_d = q.pop_front();
                    chk($sformatf("order[%0d].data", got), {16'd0, dn_s.data}, {16'd0, exp_d});
                    chk($sformatf("order[%0d].ctrl", got), {24'd0, dn_s.ctrl}, 32'h3C);
                end
                got++;
            end
            if (up_s.valid && up_s.ready) begin
                q.push_back(up_s.data);
                sent++;
            end
        end
        up_s.valid = 1'b0;
        chk("order.delivered", got, 6);
        chk("order.leftover", q.size(), 0);

        foreach (vs_n[i]) apply(1'b1, $sformatf("flat[%0d]", i), vs_n[i]);

        @(negedge clk);
        mon_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
